instruction_fetch_unit: RTL and testbench

//  Consumer end of the Program_Counter interface: owns the fetch PC, issues ordered reads to

---
 rtl/arm_fetch_pkg.sv | 19 +
 rtl/instruction_fetch_unit_if.sv | 32 +++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/instruction_fetch_unit.sv | 98 +++++++++
 tb/tb_instruction_fetch_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_fetch_pkg.sv
// rtl/arm_fetch_pkg.sv - shared widths, defaults and fetch-entry type for the fetch unit
package arm_fetch_pkg;

    localparam int              FETCH_ADDR_W   = 64;
    localparam int              FETCH_INSTR_W  = 32;
    localparam int              INSTR_BYTES    = 4;
    localparam logic [63:0]     FETCH_RESET_PC = 64'h0;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic branch_taken(input logic branch, input logic uncond_branch,
                                          input logic z_flag);
        return uncond_branch | (branch & z_flag);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - branch, instruction-memory and decode signals of the fetch unit
interface instruction_fetch_unit_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               branch;
    logic               uncond_branch;
    logic               z_flag;
    logic [ADDR_W-1:0]  br_address;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic               misalign;

    modport master (
        input  branch, uncond_branch, z_flag, br_address,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, misalign
    );

    modport slave (
        output branch, uncond_branch, z_flag, br_address,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, misalign
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small sync FIFO of fetched {pc,instr} entries with flush and registered head
module fetch_fifo
    import arm_fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  entry_t                     i_entry,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic                       o_valid,
    output entry_t                     o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [CW-1:0]   r_count;
    logic            w_pop;

    assign w_pop = i_pop & (r_count != '0);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !reset) r_mem[r_wr] <= i_entry;
    end

    // Head reads as zero when empty so no stale pc leaks out after a flush.
    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_count;
endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - owns the fetch PC, issues ordered imem reads, buffers words for decode
module instruction_fetch_unit
    import arm_fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INSTR_W  = FETCH_INSTR_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC[ADDR_W-1:0]
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [CW-1:0]     r_live;
    logic [CW-1:0]     r_drop;
    logic              r_misalign;

    logic              w_taken;
    logic [ADDR_W-1:0] w_target;
    logic              w_issue;
    logic              w_accept;
    logic              w_rsp_drop;
    logic              w_rsp_live;
    logic              w_push;
    logic              w_valid;
    logic [CW-1:0]     w_count;
    logic [ADDR_W-1:0] w_rsp_pc;
    entry_t            w_push_entry;
    entry_t            w_head;

    assign w_taken  = branch_taken(bus.branch, bus.uncond_branch, bus.z_flag);
    assign w_target = {bus.br_address[ADDR_W-1:2], 2'b00};

    // Credit rule: in-flight live reads plus buffered words never exceed DEPTH.
    assign w_issue  = !reset && !w_taken
                   && (SW'(r_live) + SW'(w_count) < SW'(DEPTH))
                   && (SW'(r_live) + SW'(r_drop)  < SW'(DEPTH));
    assign w_accept = w_issue & bus.imem_req_ready;

    assign w_rsp_drop = bus.imem_rsp_valid && (r_drop != '0);
    assign w_rsp_live = bus.imem_rsp_valid && (r_drop == '0) && (r_live != '0);
    assign w_push     = w_rsp_live & !w_taken;

    // Live reads are consecutive words ending just below fetch_pc, so the oldest one is recoverable.
    assign w_rsp_pc     = r_fetch_pc - (ADDR_W'(r_live) << 2);
    assign w_push_entry = '{pc: w_rsp_pc, instr: bus.imem_rsp_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_live     <= '0;
            r_drop     <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_taken & (bus.br_address[1:0] != 2'b00);
            if (w_taken) begin
                r_fetch_pc <= w_target;
                r_live     <= '0;
                r_drop     <= r_drop - CW'(w_rsp_drop) + r_live - CW'(w_rsp_live);
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + ADDR_W'(INSTR_BYTES);
                r_live <= r_live + CW'(w_accept) - CW'(w_rsp_live);
                r_drop <= r_drop - CW'(w_rsp_drop);
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (bus.if_ready),
        .i_flush (w_taken),
        .o_valid (w_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.imem_req_valid = w_issue;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.if_valid       = w_valid;
    assign bus.if_instr       = w_head.instr;
    assign bus.if_pc          = w_head.pc;
    assign bus.misalign       = r_misalign;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized and directed bench with in-order memory and program-path model
module tb_instruction_fetch_unit;
    localparam int          AW    = 64;
    localparam int          IW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [63:0] RPC   = 64'h0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    instruction_fetch_unit #(
        .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_PC(RPC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [63:0] dlog[$];
    logic [63:0] ilog[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          lat = 1;
    int          rdy_pct = 100;
    int          mrdy_pct = 100;
    int          deliveries = 0;
    int          d0;
    logic [63:0] exp_pc;
    bit          exp_mis;
    bit          prev_hold;
    logic [63:0] prev_pc;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [63:0] dl(input int i);
        return (i < dlog.size()) ? dlog[i] : 64'hDEAD_BEEF;
    endfunction

    function automatic logic [63:0] il(input int i);
        return (i < ilog.size()) ? ilog[i] : 64'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; entered and left just after a falling edge.
    task automatic step(input bit br, input bit ub, input bit z, input logic [63:0] ba);
        bit    taken;
        mreq_t m;
        check("misalign", bus.misalign, exp_mis);
        if (prev_hold) begin
            check("hold_valid", bus.if_valid, 1);
            check("hold_pc", bus.if_pc, prev_pc);
        end
        bus.branch         = br;
        bus.uncond_branch  = ub;
        bus.z_flag         = z;
        bus.br_address     = ba;
        bus.if_ready       = ($urandom_range(0, 99) < rdy_pct);
        bus.imem_req_ready = ($urandom_range(0, 99) < mrdy_pct);
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        #1;
        taken = ub | (br & z);
        if (taken) check("no_req_on_redirect", bus.imem_req_valid, 0);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_align", bus.imem_req_addr[1:0], 0);
            m.addr = bus.imem_req_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
            ilog.push_back(bus.imem_req_addr);
        end
        if (mq.size() > DEPTH) check("inflight_cap", mq.size(), DEPTH);
        if (bus.if_valid && bus.if_ready) begin
            check("if_pc", bus.if_pc, exp_pc);
            check("if_instr", bus.if_instr, mem_word(exp_pc));
            dlog.push_back(bus.if_pc);
            exp_pc = exp_pc + 64'd4;
            deliveries++;
        end
        prev_hold = bus.if_valid && !bus.if_ready && !taken;
        prev_pc   = bus.if_pc;
        if (taken) exp_pc = {ba[63:2], 2'b00};
        exp_mis = taken && (ba[1:0] != 2'b00);
        cyc++;
        @(negedge clk);
    endtask

    task automatic rstep(input int br_pct);
        bit          br = 0;
        bit          ub = 0;
        bit          z  = 1'($urandom);
        logic [63:0] a  = 64'($urandom_range(0, 1023));
        if ($urandom_range(0, 99) < br_pct) begin
            case ($urandom_range(0, 2))
                0:       br = 1;
                1:       ub = 1;
                default: begin br = 1; z = 0; end
            endcase
        end
        step(br, ub, z, a);
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.branch         = 1'b0;
        bus.uncond_branch  = 1'b0;
        bus.z_flag         = 1'b0;
        bus.br_address     = '0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.if_ready       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_if_valid", bus.if_valid, 0);
        check("rst_if_instr", bus.if_instr, 0);
        check("rst_if_pc", bus.if_pc, 0);
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_misalign", bus.misalign, 0);
        reset = 1'b0;
        mq.delete();
        dlog.delete();
        ilog.delete();
        exp_pc    = RPC;
        exp_mis   = 0;
        prev_hold = 0;
        #1;
        check("post_rst_req_valid", bus.imem_req_valid, 1);
        check("post_rst_req_addr", bus.imem_req_addr, RPC);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        @(negedge clk);

        lat = 1; rdy_pct = 100; mrdy_pct = 100;
        do_reset();
        repeat (20) step(0, 0, 0, '0);
        check("t1_req0", il(0), 64'h0);
        check("t1_req1", il(1), 64'h4);
        check("t1_req2", il(2), 64'h8);
        check("t1_pc2", dl(2), 64'h8);
        check("t1_progress", deliveries >= 8, 1);

        do_reset();
        rdy_pct = 0;
        repeat (10) step(0, 0, 0, '0);
        check("t2_reqs", ilog.size(), 2);
        check("t2_hold_valid", bus.if_valid, 1);
        check("t2_hold_pc", bus.if_pc, 64'h0);
        rdy_pct = 100;
        repeat (10) step(0, 0, 0, '0);
        check("t2_pc0", dl(0), 64'h0);
        check("t2_pc1", dl(1), 64'h4);
        check("t2_pc2", dl(2), 64'h8);

        lat = 3;
        do_reset();
        repeat (2) step(0, 0, 0, '0);
        check("t3_inflight", mq.size(), 2);
        step(0, 1, 0, 64'h40);
        repeat (20) step(0, 0, 0, '0);
        check("t3_pc0", dl(0), 64'h40);
        check("t3_pc1", dl(1), 64'h44);

        lat = 1;
        do_reset();
        repeat (4) step(0, 0, 0, '0);
        d0 = deliveries;
        step(1, 0, 0, 64'h80);
        repeat (6) step(0, 0, 0, '0);
        check("t4_not_taken_flow", deliveries > d0 + 2, 1);
        step(1, 0, 1, 64'h2);
        check("t4_misalign_pulse", bus.misalign, 1);
        step(0, 0, 0, '0);
        check("t4_misalign_clear", bus.misalign, 0);
        repeat (8) step(0, 0, 0, '0);

        do_reset();
        repeat (2) step(0, 0, 0, '0);
        check("t5_valid_before", bus.if_valid, 1);
        check("t5_rsp_due", mq.size(), 1);
        step(0, 1, 0, 64'h100);
        repeat (10) step(0, 0, 0, '0);
        check("t5_popped", dl(0), 64'h0);
        check("t5_redirect", dl(1), 64'h100);

        step(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF8);
        repeat (12) step(0, 0, 0, '0);
        check("wrap_progress", dlog[dlog.size()-1] < 64'h40, 1);

        lat = 3; rdy_pct = 0;
        repeat (12) step(0, 0, 0, '0);
        check("t6_full", bus.if_valid, 1);
        do_reset();
        check("t6_pc_after", bus.if_pc, 0);

        for (int s = 0; s < 8; s++) begin
            lat      = $urandom_range(1, 4);
            rdy_pct  = $urandom_range(20, 100);
            mrdy_pct = $urandom_range(30, 100);
            if (s % 3 == 0) do_reset();
            d0 = deliveries;
            repeat (400) rstep(10);
            check("rand_progress", deliveries > d0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
